// File: rtl/mem_req_ctrl_if.sv
// Requester, response and memory-side signals of mem_req_ctrl, bundled as one interface.
// The slave modport is the controller's view; master is the requester/memory side.
interface mem_req_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_len;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_last;
    logic        mem_cen;
    logic        mem_wen;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_len, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_last,
               mem_cen, mem_wen, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_len, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_last,
               mem_cen, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Single-port memory request controller: IDLE/ACCESS/CAPTURE/RESP per beat.
// Define MEM_REQ_BURST_EN to enable multi-beat reads of req_len+1 beats.
module mem_req_ctrl (
    input  logic          clk,
    input  logic          rst,
    mem_req_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  beats_q, beats_d;
    logic [1:0]  accept_len;

`ifdef MEM_REQ_BURST_EN
    // Writes are always single-beat; only reads honour req_len.
    assign accept_len = bus.req_we ? 2'd0 : bus.req_len;
`else
    logic unused_len;
    assign unused_len = ^bus.req_len;
    assign accept_len = 2'd0;
`endif

    always_comb begin
        // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        beats_d = beats_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = ACCESS;
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    beats_d = accept_len;
                end
            end
            ACCESS:  state_d = we_q ? IDLE : CAPTURE;
            CAPTURE: begin
                rdata_d = bus.mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (beats_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    // 12-bit wrap from 0xFFF to 0x000 falls out of the natural width.
                    beats_d = beats_q - 2'd1;
                    addr_d  = addr_q + 12'd1;
                    state_d = ACCESS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 12'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            beats_q <= 2'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            beats_q <= beats_d;
        end
    end

    // Strobes decode straight from the state register so reset clears them at once.
    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign bus.mem_cen   = (state_q == ACCESS);
    assign bus.mem_wen   = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_last  = (state_q == RESP) && (beats_q == 2'd0);
    assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural synchronous memory.
// Unwritten memory words read back as {20'hC0DE0, addr}.
module tb_mem_req_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cen_cnt;
    int   cen_base;

    mem_req_ctrl_if bus ();

    mem_req_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit [31:0] mem     [4096];
    bit        written [4096];

    always @(posedge clk) begin
        if (bus.mem_cen === 1'b1) begin
            cen_cnt <= cen_cnt + 1;
            if (bus.mem_wen) begin
                mem[bus.mem_addr]     <= bus.mem_wdata;
                written[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= written[bus.mem_addr] ? mem[bus.mem_addr]
                                                       : {20'hC0DE0, bus.mem_addr};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [11:0] a,
                         input logic [31:0] d, input logic [1:0] len);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_len   = len;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cen_cnt = 0;
        rst     = 1'b0;
        drive(1'b0, 1'b0, 12'h000, 32'h0, 2'd0);
        #1 rst = 1'b1;
        #1;
        check("rst_ready",  {31'd0, bus.req_ready}, 32'd0);
        check("rst_cen",    {31'd0, bus.mem_cen},   32'd0);
        check("rst_wen",    {31'd0, bus.mem_wen},   32'd0);
        check("rst_addr",   {20'd0, bus.mem_addr},  32'd0);
        check("rst_wdata",  bus.mem_wdata,          32'd0);
        check("rst_rvalid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rlast",  {31'd0, bus.rsp_last},  32'd0);
        check("rst_rdata",  bus.rsp_rdata,          32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

        // Write 0x010 <- 0xDEADBEEF: one ACCESS cycle, ready back one edge later.
        cen_base = cen_cnt;
        drive(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 2'd0);
        tick();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 2'd0);
        check("wr_cen",   {31'd0, bus.mem_cen},   32'd1);
        check("wr_wen",   {31'd0, bus.mem_wen},   32'd1);
        check("wr_addr",  {20'd0, bus.mem_addr},  32'h010);
        check("wr_wdata", bus.mem_wdata,          32'hDEADBEEF);
        check("wr_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        check("wr_cen_off",  {31'd0, bus.mem_cen},   32'd0);
        check("wr_ready_on", {31'd0, bus.req_ready}, 32'd1);
        check("wr_no_rsp",   {31'd0, bus.rsp_valid}, 32'd0);
        check("wr_cen_cnt",  cen_cnt - cen_base,     32'd1);

        // Read 0x010: rsp_valid in the second cycle after the accept edge.
        drive(1'b1, 1'b0, 12'h010, 32'h0, 2'd0);
        tick();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 2'd0);
        check("rd_cen",  {31'd0, bus.mem_cen},  32'd1);
        check("rd_wen",  {31'd0, bus.mem_wen},  32'd0);
        check("rd_addr", {20'd0, bus.mem_addr}, 32'h010);
        tick();
        check("rd_capture_cen",  {31'd0, bus.mem_cen},   32'd0);
        check("rd_capture_rsp",  {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        check("rd_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("rd_rsp_data",  bus.rsp_rdata,          32'hDEADBEEF);
        check("rd_rsp_last",  {31'd0, bus.rsp_last},  32'd1);
        check("rd_rsp_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        check("rd_rsp_done",  {31'd0, bus.rsp_valid}, 32'd0);
        check("rd_data_hold", bus.rsp_rdata,          32'hDEADBEEF);
        check("rd_ready_on",  {31'd0, bus.req_ready}, 32'd1);

        // Back-to-back reads with req_valid held: ready returns 3 edges after the first accept.
        cen_base = cen_cnt;
        drive(1'b1, 1'b0, 12'h001, 32'h0, 2'd0);
        tick();
        bus.req_addr = 12'h002;
        check("b2b_first_addr", {20'd0, bus.mem_addr}, 32'h001);
        tick();
        tick();
        check("b2b_first_data", bus.rsp_rdata,          32'hC0DE0001);
        check("b2b_busy",       {31'd0, bus.req_ready}, 32'd0);
        tick();
        check("b2b_ready_e3", {31'd0, bus.req_ready}, 32'd1);
        check("b2b_no_cen",   {31'd0, bus.mem_cen},   32'd0);
        check("b2b_addr_e3",  {20'd0, bus.mem_addr},  32'h001);
        tick();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 2'd0);
        check("b2b_second_cen",  {31'd0, bus.mem_cen},  32'd1);
        check("b2b_second_addr", {20'd0, bus.mem_addr}, 32'h002);
        tick();
        tick();
        check("b2b_second_rsp",  {31'd0, bus.rsp_valid}, 32'd1);
        check("b2b_second_data", bus.rsp_rdata,          32'hC0DE0002);
        check("b2b_cen_cnt",     cen_cnt - cen_base,     32'd2);
        tick();

        // Request pulsed during RESP is ignored.
        drive(1'b1, 1'b0, 12'h020, 32'h0, 2'd0);
        tick();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 2'd0);
        tick();
        tick();
        check("resp_state", {31'd0, bus.rsp_valid}, 32'd1);
        drive(1'b1, 1'b1, 12'h7AA, 32'h12345678, 2'd0);
        tick();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 2'd0);
        check("ign_addr",  {20'd0, bus.mem_addr}, 32'h020);
        check("ign_cen",   {31'd0, bus.mem_cen},  32'd0);
        tick();
        check("ign_idle_cen",  {31'd0, bus.mem_cen},  32'd0);
        check("ign_idle_addr", {20'd0, bus.mem_addr}, 32'h020);

        // Reset asserted in CAPTURE abandons the read.
        drive(1'b1, 1'b0, 12'h030, 32'h0, 2'd0);
        tick();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 2'd0);
        tick();
        rst = 1'b1;
        #1;
        check("midrst_cen",   {31'd0, bus.mem_cen},   32'd0);
        check("midrst_rsp",   {31'd0, bus.rsp_valid}, 32'd0);
        check("midrst_ready", {31'd0, bus.req_ready}, 32'd0);
        check("midrst_addr",  {20'd0, bus.mem_addr},  32'd0);
        check("midrst_rdata", bus.rsp_rdata,          32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_ready_after", {31'd0, bus.req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("midrst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
            tick();
        end

`ifdef MEM_REQ_BURST_EN
        // Four-beat read wrapping 0xFFE -> 0x001.
        drive(1'b1, 1'b0, 12'hFFE, 32'h0, 2'd3);
        tick();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 2'd0);
        check("bst_addr0", {20'd0, bus.mem_addr}, 32'hFFE);
        tick();
        tick();
        check("bst_rsp0",  {31'd0, bus.rsp_valid}, 32'd1);
        check("bst_data0", bus.rsp_rdata,          32'hC0DE0FFE);
        check("bst_last0", {31'd0, bus.rsp_last},  32'd0);
        tick();
        check("bst_addr1", {20'd0, bus.mem_addr}, 32'hFFF);
        tick();
        tick();
        check("bst_data1", bus.rsp_rdata,         32'hC0DE0FFF);
        check("bst_last1", {31'd0, bus.rsp_last}, 32'd0);
        tick();
        check("bst_addr2", {20'd0, bus.mem_addr}, 32'h000);
        tick();
        tick();
        check("bst_data2", bus.rsp_rdata,         32'hC0DE0000);
        check("bst_last2", {31'd0, bus.rsp_last}, 32'd0);
        tick();
        check("bst_addr3", {20'd0, bus.mem_addr}, 32'h001);
        tick();
        tick();
        check("bst_rsp3",  {31'd0, bus.rsp_valid}, 32'd1);
        check("bst_data3", bus.rsp_rdata,          32'hC0DE0001);
        check("bst_last3", {31'd0, bus.rsp_last},  32'd1);
        tick();
        check("bst_ready", {31'd0, bus.req_ready}, 32'd1);

        // Write with req_len=3 stays single-beat.
        drive(1'b1, 1'b1, 12'h040, 32'hA5A5A5A5, 2'd3);
        tick();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 2'd0);
        check("bst_wr_cen", {31'd0, bus.mem_cen}, 32'd1);
        tick();
        check("bst_wr_ready", {31'd0, bus.req_ready}, 32'd1);
        check("bst_wr_cen_off", {31'd0, bus.mem_cen}, 32'd0);
`else
        // req_len is ignored: single beat with rsp_last set.
        drive(1'b1, 1'b0, 12'h100, 32'h0, 2'd3);
        tick();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 2'd0);
        check("len_ign_addr", {20'd0, bus.mem_addr}, 32'h100);
        tick();
        tick();
        check("len_ign_rsp",  {31'd0, bus.rsp_valid}, 32'd1);
        check("len_ign_data", bus.rsp_rdata,          32'hC0DE0100);
        check("len_ign_last", {31'd0, bus.rsp_last},  32'd1);
        tick();
        check("len_ign_ready", {31'd0, bus.req_ready}, 32'd1);
        check("len_ign_cen",   {31'd0, bus.mem_cen},   32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
